// File: rtl/pwm_ctrl_multi.sv
// pwm_ctrl_multi: multi-channel PWM generator with a shared prescaler and
// period and a per-channel duty value.
//
// Configuration (presc/period/duty) is captured into shadow registers on an
// update request and transferred to the active registers only at a period
// boundary (or immediately while disabled). This way a running PWM pulse is
// never cut short.
//
// Optional feature macro: PWM_SOFTSTART_EN
//   defined   : the shadow duty acts as a per-channel target; the active duty
//               moves one step toward it at every period boundary. While
//               disabled, the target is applied directly.
//   undefined : the active duty takes the shadow duty in one step at the
//               boundary that applies the shadow.

module pwm_ctrl_multi #(
  parameter int NumChannels = 4,
  parameter int CntWidth    = 8,
  parameter int PrescWidth  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [PrescWidth-1:0]           presc_i,
  input  logic [CntWidth-1:0]             period_i,
  input  logic [NumChannels*CntWidth-1:0] duty_i,
  input  logic                            update_i,
  output logic                            update_pend_o,
  output logic                            period_tick_o,
  output logic [NumChannels-1:0]          pwm_o
);

  // ---------------------------------------------------------------------------
  // Shadow (captured on update_i) and active (in use) configuration
  // ---------------------------------------------------------------------------
  logic [PrescWidth-1:0]                   r_presc_sh;
  logic [CntWidth-1:0]                     r_period_sh;
  logic [NumChannels-1:0][CntWidth-1:0]    r_duty_sh;
  logic                                    r_pend;

  logic [PrescWidth-1:0]                   r_presc_act;
  logic [CntWidth-1:0]                     r_period_act;
  logic [NumChannels-1:0][CntWidth-1:0]    r_duty_act;

`ifdef PWM_SOFTSTART_EN
  // Duty target the ramp is heading for; loaded when the shadow is applied.
  logic [NumChannels-1:0][CntWidth-1:0]    r_duty_tgt;
  logic [NumChannels-1:0][CntWidth-1:0]    w_duty_tgt_next;
`endif

  // ---------------------------------------------------------------------------
  // Counters and outputs
  // ---------------------------------------------------------------------------
  logic [PrescWidth-1:0]                   r_pcnt;
  logic [CntWidth-1:0]                     r_cnt;
  logic [NumChannels-1:0]                  r_pwm;

  logic                                    w_tick;
  logic                                    w_boundary;
  logic                                    w_apply;
  logic                                    w_pend_next;
  logic [PrescWidth-1:0]                   w_pcnt_next;
  logic [CntWidth-1:0]                     w_cnt_next;
  logic [NumChannels-1:0][CntWidth-1:0]    w_duty_next;
  logic [NumChannels-1:0]                  w_pwm_next;

  // Prescaler tick, period wrap ("boundary") and shadow-apply conditions.
  // Nothing ticks while disabled; a pending shadow is applied either at the
  // next boundary or, while disabled, on the very next cycle.
  always_comb begin
    w_tick     = 1'b0;
    w_boundary = 1'b0;
    w_apply    = 1'b0;
    if (en_i) begin
      w_tick     = (r_pcnt == r_presc_act);
      w_boundary = w_tick && (r_cnt == r_period_act);
      w_apply    = r_pend && w_boundary;
    end else begin
      w_apply    = r_pend;
    end
  end

  // Pending flag: a new request always (re)arms it, even when it coincides
  // with the apply of the older shadow contents.
  always_comb begin
    w_pend_next = r_pend;
    if (update_i) begin
      w_pend_next = 1'b1;
    end else if (w_apply) begin
      w_pend_next = 1'b0;
    end else begin
      w_pend_next = r_pend;
    end
  end

  // Next prescaler/period counter values; both are held at zero while
  // disabled so re-enabling starts a fresh period.
  always_comb begin
    w_pcnt_next = r_pcnt;
    w_cnt_next  = r_cnt;
    if (!en_i) begin
      w_pcnt_next = '0;
      w_cnt_next  = '0;
    end else if (w_tick) begin
      w_pcnt_next = '0;
      if (w_boundary) begin
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + CntWidth'(1);
      end
    end else begin
      w_pcnt_next = r_pcnt + PrescWidth'(1);
      w_cnt_next  = r_cnt;
    end
  end

`ifdef PWM_SOFTSTART_EN
  // Soft-start duty: the target follows the applied shadow; the active duty
  // steps by one per boundary toward it, or snaps to it while disabled.
  always_comb begin
    w_duty_tgt_next = r_duty_tgt;
    w_duty_next     = r_duty_act;
    for (int c = 0; c < NumChannels; c++) begin
      if (w_apply) begin
        w_duty_tgt_next[c] = r_duty_sh[c];
      end else begin
        w_duty_tgt_next[c] = r_duty_tgt[c];
      end
      if (!en_i) begin
        w_duty_next[c] = w_duty_tgt_next[c];
      end else if (w_boundary) begin
        if (r_duty_act[c] < w_duty_tgt_next[c]) begin
          w_duty_next[c] = r_duty_act[c] + CntWidth'(1);
        end else if (r_duty_act[c] > w_duty_tgt_next[c]) begin
          w_duty_next[c] = r_duty_act[c] - CntWidth'(1);
        end else begin
          w_duty_next[c] = r_duty_act[c];
        end
      end else begin
        w_duty_next[c] = r_duty_act[c];
      end
    end
  end
`else
  // Direct duty: the active duty takes the shadow value whenever it is applied.
  always_comb begin
    w_duty_next = r_duty_act;
    for (int c = 0; c < NumChannels; c++) begin
      if (w_apply) begin
        w_duty_next[c] = r_duty_sh[c];
      end else begin
        w_duty_next[c] = r_duty_act[c];
      end
    end
  end
`endif

  // PWM compare against the current count: full-width unsigned compare, so
  // duty 0 gives a constant low and duty > period a constant high.
  always_comb begin
    w_pwm_next = '0;
    for (int c = 0; c < NumChannels; c++) begin
      if (en_i) begin
        w_pwm_next[c] = (r_cnt < r_duty_act[c]);
      end else begin
        w_pwm_next[c] = 1'b0;
      end
    end
  end

  // Shadow capture and pending flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc_sh  <= '0;
      r_period_sh <= '0;
      r_duty_sh   <= '0;
      r_pend      <= 1'b0;
    end else begin
      if (update_i) begin
        r_presc_sh  <= presc_i;
        r_period_sh <= period_i;
        r_duty_sh   <= duty_i;
      end
      r_pend <= w_pend_next;
    end
  end

  // Active configuration; reads the old shadow when an apply coincides with
  // a new capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc_act  <= '0;
      r_period_act <= '0;
      r_duty_act   <= '0;
    end else begin
      if (w_apply) begin
        r_presc_act  <= r_presc_sh;
        r_period_act <= r_period_sh;
      end
      r_duty_act <= w_duty_next;
    end
  end

`ifdef PWM_SOFTSTART_EN
  // Soft-start target register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_duty_tgt <= '0;
    end else begin
      r_duty_tgt <= w_duty_tgt_next;
    end
  end
`endif

  // Prescaler and period counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pcnt <= '0;
      r_cnt  <= '0;
    end else begin
      r_pcnt <= w_pcnt_next;
      r_cnt  <= w_cnt_next;
    end
  end

  // Registered PWM outputs (one cycle behind the counter).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_next;
    end
  end

  // The wrap pulse is taken straight from the counter state so it is high in
  // the same cycle as the boundary it marks.
  assign period_tick_o = w_boundary;
  assign update_pend_o = r_pend;
  assign pwm_o         = r_pwm;

endmodule

// File: tb/tb_pwm_ctrl_multi.sv
// Self-checking bench for pwm_ctrl_multi. Expected waveforms come from a
// position-in-period model: t cycles after enable, the count is
// (t mod P)/(presc+1) with P=(presc+1)*(period+1), and a channel is high
// when that count is below its duty.

module tb_pwm_ctrl_multi;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int PW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               update;
  logic [PW-1:0]      presc;
  logic [CW-1:0]      period;
  logic [NC*CW-1:0]   duty;
  logic               pend;
  logic               tick;
  logic [NC-1:0]      pwm;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PWM_SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  always #5 clk = ~clk;

  pwm_ctrl_multi #(.NumChannels(NC), .CntWidth(CW), .PrescWidth(PW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .presc_i(presc), .period_i(period),
    .duty_i(duty), .update_i(update), .update_pend_o(pend),
    .period_tick_o(tick), .pwm_o(pwm)
  );

  function automatic logic exp_level(int t, int pr, int per, int d);
    int p_len;
    int cnt;
    p_len = (pr + 1) * (per + 1);
    cnt   = (t % p_len) / (pr + 1);
    return (cnt < d);
  endfunction

  function automatic logic exp_tick(int k, int pr, int per);
    int p_len;
    p_len = (pr + 1) * (per + 1);
    return (((k + 1) % p_len) == (p_len - 1));
  endfunction

  function automatic logic [NC*CW-1:0] pack4(int d0, int d1, int d2, int d3);
    logic [NC*CW-1:0] v;
    v[0*CW +: CW] = CW'(d0);
    v[1*CW +: CW] = CW'(d1);
    v[2*CW +: CW] = CW'(d2);
    v[3*CW +: CW] = CW'(d3);
    return v;
  endfunction

  // Load a configuration while disabled, then enable at a negedge.
  task automatic configure(input int pr, input int per, input logic [NC*CW-1:0] dv);
    @(negedge clk);
    en = 1'b0; update = 1'b1;
    presc = PW'(pr); period = CW'(per); duty = dv;
    @(negedge clk);
    update = 1'b0;
    presc = PW'($urandom); period = CW'($urandom); duty = NC*CW'($urandom);
    n_tests++;
    if (pend !== 1'b1) begin n_fail++; $display("FAIL cfg_pend_set got %b exp 1", pend); end
    @(negedge clk);
    n_tests++;
    if (pend !== 1'b0) begin n_fail++; $display("FAIL cfg_pend_clr got %b exp 0", pend); end
    en = 1'b1;
  endtask

  // Check pwm and tick for ncyc cycles of steady running from period start.
  task automatic check_window(input int pr, input int per, input logic [NC*CW-1:0] dv,
                              input int ncyc, input string name);
    logic e;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) begin
        e = exp_level(k, pr, per, int'(dv[c*CW +: CW]));
        n_tests++;
        if (pwm[c] !== e) begin
          n_fail++;
          $display("FAIL %s pwm[%0d] k=%0d got %b exp %b", name, c, k, pwm[c], e);
        end
      end
      e = exp_tick(k, pr, per);
      n_tests++;
      if (tick !== e) begin
        n_fail++;
        $display("FAIL %s tick k=%0d got %b exp %b", name, k, tick, e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; update = 1'b0;
    presc = '0; period = '0; duty = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (pwm !== 4'b0000) begin n_fail++; $display("FAIL reset_pwm got %b exp 0000", pwm); end
    n_tests++;
    if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b exp 0", pend); end
    n_tests++;
    if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int highs;
    int ticks;
    configure(0, 9, pack4(3, 0, 0, 0));
    highs = 0; ticks = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      highs += int'(pwm[0]);
      ticks += int'(tick);
    end
    n_tests++;
    if (highs != 3) begin n_fail++; $display("FAIL basic_highs got %0d exp 3", highs); end
    n_tests++;
    if (ticks != 1) begin n_fail++; $display("FAIL basic_ticks got %0d exp 1", ticks); end
    configure(0, 9, pack4(3, 0, 0, 0));
    check_window(0, 9, pack4(3, 0, 0, 0), 30, "basic");
  endtask

  task automatic test_multi();
    configure(3, 3, pack4(0, 2, 4, 255));
    check_window(3, 3, pack4(0, 2, 4, 255), 40, "multi");
  endtask

  task automatic test_midupdate();
    int d;
    logic e;
    configure(0, 9, pack4(2, 0, 0, 0));
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      update = 1'b0;
      d = (k < 10) ? 2 : (SOFT ? 3 : 6);
      e = exp_level(k, 0, 9, d);
      n_tests++;
      if (pwm[0] !== e) begin n_fail++; $display("FAIL mid_pwm k=%0d got %b exp %b", k, pwm[0], e); end
      e = (k >= 5 && k <= 8);
      n_tests++;
      if (pend !== e) begin n_fail++; $display("FAIL mid_pend k=%0d got %b exp %b", k, pend, e); end
      if (k == 4) begin
        update = 1'b1; presc = '0; period = CW'(9); duty = pack4(6, 0, 0, 0);
      end
    end
  endtask

  task automatic test_coincident();
    int d;
    logic e;
    configure(0, 4, pack4(1, 0, 0, 0));
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      update = 1'b0;
      d = (k < 10) ? 1 : (SOFT ? 2 : 3);
      e = exp_level(k, 0, 4, d);
      n_tests++;
      if (pwm[0] !== e) begin n_fail++; $display("FAIL coin_pwm k=%0d got %b exp %b", k, pwm[0], e); end
      e = exp_tick(k, 0, 4);
      n_tests++;
      if (tick !== e) begin n_fail++; $display("FAIL coin_tick k=%0d got %b exp %b", k, tick, e); end
      e = (k >= 4 && k <= 8);
      n_tests++;
      if (pend !== e) begin n_fail++; $display("FAIL coin_pend k=%0d got %b exp %b", k, pend, e); end
      if (k == 3) begin
        update = 1'b1; presc = '0; period = CW'(4); duty = pack4(3, 0, 0, 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    configure(0, 9, pack4(5, 5, 5, 5));
    repeat (3) @(posedge clk);
    #1;
    update = 1'b1; duty = pack4(7, 7, 7, 7);
    @(posedge clk); #1;
    update = 1'b0;
    n_tests++;
    if (pend !== 1'b1) begin n_fail++; $display("FAIL rstmid_pend_pre got %b exp 1", pend); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (pwm !== 4'b0000) begin n_fail++; $display("FAIL rstmid_pwm got %b exp 0000", pwm); end
    n_tests++;
    if (pend !== 1'b0) begin n_fail++; $display("FAIL rstmid_pend got %b exp 0", pend); end
    check_window(0, 0, pack4(0, 0, 0, 0), 12, "rstmid_run");
  endtask

  task automatic test_softstart();
    int highs[5];
    int exp_h;
    configure(0, 3, pack4(0, 0, 0, 0));
    for (int p = 0; p < 5; p++) highs[p] = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      update = 1'b0;
      highs[k / 4] += int'(pwm[0]);
      if (k == 0) begin
        update = 1'b1; presc = '0; period = CW'(3); duty = pack4(4, 0, 0, 0);
      end
    end
    for (int p = 0; p < 5; p++) begin
      exp_h = (p == 0) ? 0 : (SOFT ? p : 4);
      n_tests++;
      if (highs[p] != exp_h) begin
        n_fail++; $display("FAIL soft_period%0d got %0d exp %0d", p, highs[p], exp_h);
      end
    end
  endtask

  task automatic test_disable();
    configure(1, 5, pack4(3, 7, 1, 0));
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (pwm !== 4'b0000) begin n_fail++; $display("FAIL dis_pwm k=%0d got %b exp 0000", k, pwm); end
      n_tests++;
      if (tick !== 1'b0) begin n_fail++; $display("FAIL dis_tick k=%0d got %b exp 0", k, tick); end
    end
    en = 1'b1;
    check_window(1, 5, pack4(3, 7, 1, 0), 30, "reenable");
  endtask

  task automatic test_random();
    int pr;
    int per;
    int d[NC];
    logic [NC*CW-1:0] dv;
    for (int it = 0; it < 8; it++) begin
      pr  = $urandom_range(0, 3);
      per = $urandom_range(0, 12);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 4) == 0) d[c] = 255;
        else d[c] = $urandom_range(0, per + 2);
      end
      dv = pack4(d[0], d[1], d[2], d[3]);
      configure(pr, per, dv);
      check_window(pr, per, dv, 2 * (pr + 1) * (per + 1) + 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_midupdate();
    test_coincident();
    test_reset_mid();
    test_softstart();
    test_disable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
